// File: rtl/wb_ram_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter_2m
//
// Two-master Wishbone arbiter that shares one synchronous RAM bridge slave
// between the OpenMIPS instruction bus (m0) and data bus (m1).
//
// Ownership is granted per bus cycle: a master keeps the slave for as long as
// it holds cyc, so multi-beat sequences such as read-modify-write are never
// split. Ties go round-robin. A grant decided at a clock edge takes effect
// in the following cycle.
//
// While a master owns the slave, its request is passed combinationally to the
// slave port, and ack is returned to the owner only. The other master sees
// no ack and no err, so it stalls. A per-transfer watchdog raises a one-cycle
// err pulse to the owner if the slave does not ack within TIMEOUT cycles.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   m{0,1}_cyc/stb/we_i     master cycle, strobe and write enable
//   m{0,1}_addr/data/sel_i  master address, write data and byte select
//   m{0,1}_data_o           read data (always s_data_i)
//   m{0,1}_ack_o, _err_o    acknowledge and watchdog-timeout pulse to a master
//   s_cyc/stb/we_o          slave cycle, strobe and write enable
//   s_addr/data/sel_o       slave address, write data and byte select
//   s_data_i, s_ack_i       slave read data and acknowledge
//   grant_o                 one-hot owner (bit0 = m0, bit1 = m1), 00 = idle
// -----------------------------------------------------------------------------
module wb_ram_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0 (instruction bus)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  // master 1 (data bus)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  // shared slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  // arbitration status
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  // Most recently granted master: 0 = m0, 1 = m1. Reset to 1 so m0 wins the
  // first tie.
  logic   last_q, last_d;

  logic req0, req1;
  logic own0, own1;
  logic timeout_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // ---------------------------------------------------------------------------
  // Arbitration / ownership
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        // Release re-arbitrates on the same edge; the other master has
        // priority, so a waiting m1 takes over without an idle cycle.
        if (!m0_cyc_i) begin
          if (req1) begin
            state_d = OWN1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          if (req0) begin
            state_d = OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign grant_o = {own1, own0};

  // ---------------------------------------------------------------------------
  // Request mux towards the slave, response routing back to the owner
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
    end
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // An ack arriving in IDLE (abandoned transfer) reaches nobody.
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & timeout_hit;
  assign m1_err_o = own1 & timeout_hit;

  // ---------------------------------------------------------------------------
  // Watchdog: counts owner cycles with stb high and no ack. The err pulse is
  // qualified by !s_ack_i, so an ack on the threshold cycle wins.
  // ---------------------------------------------------------------------------
  if (TIMEOUT > 0) begin : g_watchdog
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    assign waiting     = (own0 | own1) & s_stb_o & ~s_ack_i;
    assign timeout_hit = waiting && (cnt_q == LIMIT);

    // The counter clears on the threshold, so it tops out at TIMEOUT-1 and
    // never wraps.
    always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!waiting || timeout_hit || (state_d != state_q)) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_no_watchdog
    assign timeout_hit = 1'b0;
  end

endmodule

// File: tb/tb_wb_ram_arbiter_2m.sv
// -----------------------------------------------------------------------------
// Testbench for wb_ram_arbiter_2m.
// Two instances share all inputs: dut (TIMEOUT = 4) is the main one and dut_b
// (TIMEOUT = 2) is used for the ack-versus-timeout race. Every transfer the
// stimulus expects to complete is pushed into a queue. A negedge monitor pops
// one entry per acked slave beat on dut and compares the routed request and
// response against it.
// -----------------------------------------------------------------------------
module tb_wb_ram_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk, rst_n;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i, s_data_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic s_ack_i;

  logic [DW-1:0] m0_data_o, m1_data_o, s_data_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [SW-1:0] s_sel_o;
  logic [1:0] grant_o;

  logic [DW-1:0] m0_data_o_b, m1_data_o_b, s_data_o_b;
  logic m0_ack_o_b, m0_err_o_b, m1_ack_o_b, m1_err_o_b;
  logic s_cyc_o_b, s_stb_o_b, s_we_o_b;
  logic [AW-1:0] s_addr_o_b;
  logic [SW-1:0] s_sel_o_b;
  logic [1:0] grant_o_b;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [1:0]    grant;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } xfer_t;

  xfer_t sb_q[$];

  wb_ram_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  wb_ram_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_data_o(m0_data_o_b), .m0_ack_o(m0_ack_o_b),
    .m0_err_o(m0_err_o_b),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_data_o(m1_data_o_b), .m1_ack_o(m1_ack_o_b),
    .m1_err_o(m1_err_o_b),
    .s_cyc_o(s_cyc_o_b), .s_stb_o(s_stb_o_b), .s_we_o(s_we_o_b), .s_addr_o(s_addr_o_b),
    .s_data_o(s_data_o_b), .s_sel_o(s_sel_o_b), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: one pop per acked slave beat.
  always @(negedge clk) begin
    if (rst_n && s_cyc_o && s_stb_o && s_ack_i) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected_ack: grant=%b addr=%h, required no transfer", grant_o, s_addr_o);
      end else begin
        xfer_t e;
        e = sb_q.pop_front();
        if (grant_o !== e.grant || s_we_o !== e.we || s_addr_o !== e.addr) begin
          n_fails++;
          $display("FAIL sb_request: grant=%b we=%b addr=%h, required grant=%b we=%b addr=%h",
                   grant_o, s_we_o, s_addr_o, e.grant, e.we, e.addr);
        end
        n_checks++;
        if (e.we && (s_data_o !== e.wdata || s_sel_o !== 4'hF)) begin
          n_fails++;
          $display("FAIL sb_wdata: data=%h sel=%h, required data=%h sel=f", s_data_o, s_sel_o, e.wdata);
        end
        n_checks++;
        if (e.grant == 2'b01 && (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 ||
                                 (!e.we && m0_data_o !== e.rdata))) begin
          n_fails++;
          $display("FAIL sb_resp_m0: ack0=%b ack1=%b data=%h, required ack0=1 ack1=0 data=%h",
                   m0_ack_o, m1_ack_o, m0_data_o, e.rdata);
        end
        if (e.grant == 2'b10 && (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 ||
                                 (!e.we && m1_data_o !== e.rdata))) begin
          n_fails++;
          $display("FAIL sb_resp_m1: ack1=%b ack0=%b data=%h, required ack1=1 ack0=0 data=%h",
                   m1_ack_o, m0_ack_o, m1_data_o, e.rdata);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0;
    s_ack_i = 0; s_data_i = '0;
  endtask

  task automatic push(input logic [1:0] g, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    xfer_t e;
    e.grant = g; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b00 || s_cyc_o !== 0 || s_stb_o !== 0 || m0_ack_o !== 0 ||
        m1_ack_o !== 0 || m0_err_o !== 0 || m1_err_o !== 0) begin
      n_fails++;
      $display("FAIL reset_state: grant=%b cyc=%b stb=%b acks=%b%b errs=%b%b, required all 0",
               grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o);
    end
    next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_single_read();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 32'h100; m0_sel_i = 4'hF;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b00 || s_cyc_o !== 0) begin
      n_fails++;
      $display("FAIL read_arb_latency: grant=%b s_cyc=%b, required 00/0", grant_o, s_cyc_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b01 || s_addr_o !== 32'h100 || s_stb_o !== 1 || m0_ack_o !== 0) begin
      n_fails++;
      $display("FAIL read_grant: grant=%b addr=%h stb=%b ack=%b, required 01/100/1/0",
               grant_o, s_addr_o, s_stb_o, m0_ack_o);
    end
    next_cycle();
    push(2'b01, 0, 32'h100, '0, 32'hDEADBEEF);
    s_ack_i = 1; s_data_i = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (m0_ack_o !== 1 || m0_data_o !== 32'hDEADBEEF || m1_ack_o !== 0 || m1_data_o !== 32'hDEADBEEF) begin
      n_fails++;
      $display("FAIL read_ack: ack0=%b data0=%h ack1=%b data1=%h, required 1/deadbeef/0/deadbeef",
               m0_ack_o, m0_data_o, m1_ack_o, m1_data_o);
    end
    next_cycle();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    // Now IDLE: a late slave ack must not reach anybody.
    s_ack_i = 1;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b00 || m0_ack_o !== 0 || m1_ack_o !== 0) begin
      n_fails++;
      $display("FAIL idle_ack_ignored: grant=%b ack0=%b ack1=%b, required 00/0/0", grant_o, m0_ack_o, m1_ack_o);
    end
    next_cycle();
    s_ack_i = 0;
  endtask

  task automatic test_tie();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h200;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h300;
    next_cycle();
    push(2'b01, 0, 32'h200, '0, 32'hA0A00200);
    s_ack_i = 1; s_data_i = 32'hA0A00200;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b01) begin
      n_fails++;
      $display("FAIL tie_first_m0: grant=%b, required 01", grant_o);
    end
    next_cycle();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    next_cycle();
    push(2'b10, 0, 32'h300, '0, 32'hB0B00300);
    s_ack_i = 1; s_data_i = 32'hB0B00300;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b10 || s_addr_o !== 32'h300) begin
      n_fails++;
      $display("FAIL tie_handover: grant=%b addr=%h, required 10/300", grant_o, s_addr_o);
    end
    next_cycle();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b00) begin
      n_fails++;
      $display("FAIL tie_idle_between: grant=%b, required 00", grant_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b01) begin
      n_fails++;
      $display("FAIL tie_second_m0: grant=%b, required 01", grant_o);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_burst();
    logic [DW-1:0] beat_data [3];
    beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF;
    m1_addr_i = 32'h10; m1_data_i = beat_data[0];
    next_cycle();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400;
    for (int b = 0; b < 3; b++) begin
      m1_stb_i = 1; m1_addr_i = 32'h10 + 32'(4 * b); m1_data_i = beat_data[b];
      push(2'b10, 1, 32'h10 + 32'(4 * b), beat_data[b], '0);
      s_ack_i = 1;
      @(negedge clk);
      n_checks++;
      if (grant_o !== 2'b10 || m0_ack_o !== 0) begin
        n_fails++;
        $display("FAIL burst_beat%0d: grant=%b ack0=%b, required 10/0", b, grant_o, m0_ack_o);
      end
      next_cycle();
      // stb gap between beats; cyc stays high
      m1_stb_i = 0; s_ack_i = 0;
      @(negedge clk);
      n_checks++;
      if (grant_o !== 2'b10 || s_cyc_o !== 1 || s_stb_o !== 0) begin
        n_fails++;
        $display("FAIL burst_gap%0d: grant=%b cyc=%b stb=%b, required 10/1/0", b, grant_o, s_cyc_o, s_stb_o);
      end
      next_cycle();
    end
    m1_cyc_i = 0; m1_we_i = 0;
    next_cycle();
    push(2'b01, 0, 32'h400, '0, 32'hC0DE0400);
    s_ack_i = 1; s_data_i = 32'hC0DE0400;
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b01 || s_addr_o !== 32'h400) begin
      n_fails++;
      $display("FAIL burst_m0_after: grant=%b addr=%h, required 01/400", grant_o, s_addr_o);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_watchdog();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h500;
    next_cycle();
    for (int w = 1; w <= 12; w++) begin
      logic exp_err, exp_err_b;
      exp_err   = (w % 4 == 0);
      exp_err_b = (w % 2 == 0);
      @(negedge clk);
      n_checks++;
      if (grant_o !== 2'b01 || m0_err_o !== exp_err || m1_err_o !== 0 || m0_ack_o !== 0) begin
        n_fails++;
        $display("FAIL wdog_t4_cycle%0d: grant=%b err0=%b err1=%b ack0=%b, required 01/%b/0/0",
                 w, grant_o, m0_err_o, m1_err_o, m0_ack_o, exp_err);
      end
      n_checks++;
      if (m0_err_o_b !== exp_err_b) begin
        n_fails++;
        $display("FAIL wdog_t2_cycle%0d: err0=%b, required %b", w, m0_err_o_b, exp_err_b);
      end
      next_cycle();
    end
    push(2'b01, 0, 32'h500, '0, 32'h55);
    s_ack_i = 1; s_data_i = 32'h55;
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_ack_wins();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h600;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (m0_err_o_b !== 0 || m0_ack_o_b !== 0) begin
      n_fails++;
      $display("FAIL ackwin_wait: err=%b ack=%b, required 0/0", m0_err_o_b, m0_ack_o_b);
    end
    next_cycle();
    push(2'b01, 0, 32'h600, '0, 32'h600D600D);
    s_ack_i = 1; s_data_i = 32'h600D600D;
    @(negedge clk);
    n_checks++;
    if (m0_ack_o_b !== 1 || m0_err_o_b !== 0 || m0_err_o !== 0) begin
      n_fails++;
      $display("FAIL ackwin_race: ack=%b err=%b err_t4=%b, required 1/0/0", m0_ack_o_b, m0_err_o_b, m0_err_o);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_async_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h700;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b10 || s_stb_o !== 1) begin
      n_fails++;
      $display("FAIL areset_setup: grant=%b stb=%b, required 10/1", grant_o, s_stb_o);
    end
    #1;
    rst_n = 0;
    s_ack_i = 1;
    #1;
    n_checks++;
    if (s_cyc_o !== 0 || s_stb_o !== 0 || grant_o !== 2'b00 || m1_ack_o !== 0 || s_addr_o !== '0) begin
      n_fails++;
      $display("FAIL areset_immediate: cyc=%b stb=%b grant=%b ack1=%b addr=%h, required all 0",
               s_cyc_o, s_stb_o, grant_o, m1_ack_o, s_addr_o);
    end
    next_cycle();
    rst_n = 1; s_ack_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h800;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b01) begin
      n_fails++;
      $display("FAIL areset_tie_m0: grant=%b, required 01", grant_o);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_watchdog();
    test_ack_wins();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_drain: %0d transfers never acked, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
